// File: rtl/pipeline_hazard_ctrl_if.sv
// Handshake bundle between the opcode decoder/datapath and the hazard controller.
// The decoder side is the master; the controller is the slave.
interface pipeline_hazard_ctrl_if #(
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] id_rs;
    logic [ADDR_WIDTH-1:0] id_rt;
    logic                  id_reads_rt;
    logic                  id_write_reg;
    logic [ADDR_WIDTH-1:0] id_wnum;
    logic                  id_is_branch;
    logic                  id_is_jump;
    logic                  id_is_halt;
    logic                  ex_mem_alu_zero;

    logic                  is_load_PC;
    logic [1:0]            control_mux_for_PC;
    logic                  is_IFID_open;
    logic                  is_IDEX_open;
    logic                  is_EXMEM_open;
    logic                  is_MEMWB_open;
    logic                  ex_valid;
    logic                  mem_valid;
    logic                  wb_valid;
    logic                  halted;

    modport master (
        output id_rs, id_rt, id_reads_rt, id_write_reg, id_wnum,
               id_is_branch, id_is_jump, id_is_halt, ex_mem_alu_zero,
        input  is_load_PC, control_mux_for_PC, is_IFID_open, is_IDEX_open,
               is_EXMEM_open, is_MEMWB_open, ex_valid, mem_valid, wb_valid, halted
    );

    modport slave (
        input  id_rs, id_rt, id_reads_rt, id_write_reg, id_wnum,
               id_is_branch, id_is_jump, id_is_halt, ex_mem_alu_zero,
        output is_load_PC, control_mux_for_PC, is_IFID_open, is_IDEX_open,
               is_EXMEM_open, is_MEMWB_open, ex_valid, mem_valid, wb_valid, halted
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Sequencing controller for a 5-stage pipeline: RAW stalls, branch/jump flushes
// and halt draining, driven from per-stage valid bits and destination tags.
module pipeline_hazard_ctrl #(
    parameter int WIDTH        = 32,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave hz
);
    localparam int ADDR_WIDTH = $clog2(WIDTH);
    localparam int CNT_W      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_v_id;
    logic                  r_v_ex;
    logic                  r_ex_wr;
    logic [ADDR_WIDTH-1:0] r_ex_wnum;
    logic                  r_ex_br;
    logic                  r_ex_jmp;
    logic                  r_v_mem;
    logic                  r_mem_wr;
    logic [ADDR_WIDTH-1:0] r_mem_wnum;
    logic                  r_mem_br;
    logic                  r_v_wb;
    logic                  r_wb_wr;
    logic [ADDR_WIDTH-1:0] r_wb_wnum;

    logic w_ex_writer, w_mem_writer, w_wb_writer;
    logic w_rs_hit, w_rt_hit, w_hazard;
    logic w_run, w_drain, w_halted, w_live;
    logic w_redir_br, w_redir_jp, w_stall, w_halt_go, w_advance, w_load_pc;

    // r0 is never a real destination, so it can never create a dependency.
    assign w_ex_writer  = r_v_ex  & r_ex_wr  & (r_ex_wnum  != '0);
    assign w_mem_writer = r_v_mem & r_mem_wr & (r_mem_wnum != '0);
    assign w_wb_writer  = r_v_wb  & r_wb_wr  & (r_wb_wnum  != '0);

    assign w_rs_hit = (w_ex_writer  && hz.id_rs == r_ex_wnum)
                   || (w_mem_writer && hz.id_rs == r_mem_wnum)
                   || (w_wb_writer  && hz.id_rs == r_wb_wnum);
    assign w_rt_hit = (w_ex_writer  && hz.id_rt == r_ex_wnum)
                   || (w_mem_writer && hz.id_rt == r_mem_wnum)
                   || (w_wb_writer  && hz.id_rt == r_wb_wnum);
    assign w_hazard = r_v_id & (w_rs_hit | (hz.id_reads_rt & w_rt_hit));

    assign w_run    = (r_state == S_RUN);
    assign w_drain  = (r_state == S_DRAIN);
    assign w_halted = (r_state == S_HALTED);

    // Oldest instruction wins: a taken branch in MEM outranks a jump in EX,
    // which outranks anything the ID instruction wants.
    assign w_redir_br = (w_run | w_drain) & r_v_mem & r_mem_br & hz.ex_mem_alu_zero;
    assign w_redir_jp = w_run & ~w_redir_br & r_v_ex & r_ex_jmp;
    assign w_stall    = w_run & ~w_redir_br & ~w_redir_jp & w_hazard;
    assign w_halt_go  = w_run & ~w_redir_br & ~w_redir_jp & ~w_hazard & r_v_id & hz.id_is_halt;
    assign w_advance  = w_run & ~w_redir_br & ~w_redir_jp & ~w_hazard & ~w_halt_go;
    assign w_load_pc  = w_redir_br | w_redir_jp | w_advance;

    // Outputs are forced quiet while reset is held, independent of the clock.
    assign w_live                = rst & ~w_halted;
    assign hz.is_load_PC         = rst & w_load_pc;
    assign hz.is_IFID_open       = rst & w_load_pc;
    assign hz.control_mux_for_PC = !rst      ? 2'd0 :
                                   w_redir_br ? 2'd1 :
                                   w_redir_jp ? 2'd2 : 2'd0;
    assign hz.is_IDEX_open       = w_live;
    assign hz.is_EXMEM_open      = w_live;
    assign hz.is_MEMWB_open      = w_live;
    assign hz.ex_valid           = w_live & r_v_ex;
    assign hz.mem_valid          = w_live & r_v_mem;
    assign hz.wb_valid           = w_live & r_v_wb;
    assign hz.halted             = rst & w_halted;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_RUN;
            r_cnt      <= '0;
            r_v_id     <= 1'b0;
            r_v_ex     <= 1'b0;
            r_ex_wr    <= 1'b0;
            r_ex_wnum  <= '0;
            r_ex_br    <= 1'b0;
            r_ex_jmp   <= 1'b0;
            r_v_mem    <= 1'b0;
            r_mem_wr   <= 1'b0;
            r_mem_wnum <= '0;
            r_mem_br   <= 1'b0;
            r_v_wb     <= 1'b0;
            r_wb_wr    <= 1'b0;
            r_wb_wnum  <= '0;
        end else if (!w_halted) begin
            r_v_wb    <= r_v_mem;
            r_wb_wr   <= r_mem_wr;
            r_wb_wnum <= r_mem_wnum;
            if (w_redir_br) begin
                // A taken branch also squashes a halt that was draining behind it.
                r_v_id  <= 1'b0;
                r_v_ex  <= 1'b0;
                r_v_mem <= 1'b0;
                r_state <= S_RUN;
                r_cnt   <= '0;
            end else begin
                r_v_mem    <= r_v_ex;
                r_mem_wr   <= r_ex_wr;
                r_mem_wnum <= r_ex_wnum;
                r_mem_br   <= r_ex_br;
                if (w_advance) begin
                    r_v_id    <= 1'b1;
                    r_v_ex    <= r_v_id;
                    r_ex_wr   <= r_v_id & hz.id_write_reg;
                    r_ex_wnum <= hz.id_wnum;
                    r_ex_br   <= r_v_id & hz.id_is_branch;
                    r_ex_jmp  <= r_v_id & hz.id_is_jump;
                end else begin
                    r_v_ex    <= 1'b0;
                    r_ex_wr   <= 1'b0;
                    r_ex_wnum <= '0;
                    r_ex_br   <= 1'b0;
                    r_ex_jmp  <= 1'b0;
                    if (!w_stall) r_v_id <= 1'b0;
                end
                if (w_halt_go) begin
                    r_state <= S_DRAIN;
                    r_cnt   <= '0;
                end else if (w_drain) begin
                    if (r_cnt == CNT_LAST) r_state <= S_HALTED;
                    else                   r_cnt   <= r_cnt + 1'b1;
                end
            end
        end
    end
endmodule
